// File: rtl/sample_player_pkg.sv
// Shared definitions for the ROM sample sequencer: FSM state encoding and default sizing.
package sample_player_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int unsigned DEF_ADDR_W    = 15;
   localparam int unsigned DEF_DATA_W    = 4;
   localparam int unsigned DEF_SONG_LEN  = 25196;
   localparam int unsigned DEF_DIV_W     = 13;
   localparam int unsigned DEF_DIV_LIMIT = 32'h61b;

   // Right-shift amount for a 2-bit volume setting (3 = full scale, no shift).
   function automatic logic [1:0] vol_shift(input logic [1:0] vol);
      return 2'd3 - vol;
   endfunction

endpackage

// File: rtl/sample_rate_div.sv
// Sample-rate divider: free-running counter with enable/clear; tick on terminal count.
module sample_rate_div #(
   parameter int unsigned          DIV_W     = 13,
   parameter logic [DIV_W-1:0]     DIV_LIMIT = 13'h61b
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   logic [DIV_W-1:0] r_cnt;

   // Tick is combinational so the top can act on the same edge that wraps the counter.
   assign o_tick = i_en && (r_cnt == DIV_LIMIT);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (r_cnt == DIV_LIMIT) r_cnt <= '0;
         else                    r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sample_player.sv
// ROM sample sequencer with play/pause/stop FSM, loop or one-shot mode and restart.
// Define SAMPLE_PLAYER_VOLUME_EN to add a 2-bit volume port (logical right-shift attenuation).
module sample_player
   import sample_player_pkg::*;
#(
   parameter int unsigned      ADDR_W    = DEF_ADDR_W,
   parameter int unsigned      DATA_W    = DEF_DATA_W,
   parameter int unsigned      SONG_LEN  = DEF_SONG_LEN,
   parameter int unsigned      DIV_W     = DEF_DIV_W,
   parameter logic [DIV_W-1:0] DIV_LIMIT = DIV_W'(DEF_DIV_LIMIT)
) (
   input  logic              clk50Mghz,
   input  logic              reset,
   input  logic              play,
   input  logic              restart,
   input  logic              loop_en,
`ifdef SAMPLE_PLAYER_VOLUME_EN
   input  logic [1:0]        volume,
`endif
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] sample,
   output logic              sample_valid,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(SONG_LEN - 1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_sample;
   logic              r_valid;
   logic              r_busy;
   logic              r_done;

   logic              w_tick;
   logic              w_div_en;
   logic              w_div_clr;
   logic              w_at_end;
   logic [DATA_W-1:0] w_sample_in;

   assign w_div_en  = (r_state == PLAY);
   assign w_div_clr = restart || (r_state == IDLE) || (r_state == DONE);
   assign w_at_end  = (r_addr == LP_LAST);

`ifdef SAMPLE_PLAYER_VOLUME_EN
   assign w_sample_in = rom_data >> vol_shift(volume);
`else
   assign w_sample_in = rom_data;
`endif

   sample_rate_div #(
      .DIV_W    (DIV_W),
      .DIV_LIMIT(DIV_LIMIT)
   ) u_div (
      .i_clk (clk50Mghz),
      .i_rst (reset),
      .i_en  (w_div_en),
      .i_clr (w_div_clr),
      .o_tick(w_tick)
   );

   always_ff @(posedge clk50Mghz or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_sample <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         if (restart) begin
            // Restart overrides everything, including a tick landing on this edge.
            r_addr  <= '0;
            r_state <= play ? PLAY : IDLE;
            r_busy  <= play;
         end else begin
            case (r_state)
               IDLE: begin
                  if (play) begin
                     r_state <= PLAY;
                     r_busy  <= 1'b1;
                  end
               end
               PLAY: begin
                  if (w_tick) begin
                     r_sample <= w_sample_in;
                     r_valid  <= 1'b1;
                     r_addr   <= w_at_end ? '0 : r_addr + 1'b1;
                  end
                  // End of a one-shot song wins over a coincident pause request.
                  if (w_tick && w_at_end && !loop_en) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else if (!play) begin
                     r_state <= PAUSE;
                     r_busy  <= 1'b0;
                  end
               end
               PAUSE: begin
                  if (play) begin
                     r_state <= PLAY;
                     r_busy  <= 1'b1;
                  end
               end
               DONE: begin
                  if (!play) r_state <= IDLE;
               end
               default: begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rom_addr     = r_addr;
   assign sample       = r_sample;
   assign sample_valid = r_valid;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule
